// File: rtl/swervolf_sevseg_ctrl.sv
// Wishbone-mapped multiplexed seven-segment controller: up to 8 common-anode
// digits with hex decode, PWM brightness, per-digit blink and tear-free updates.
module swervolf_sevseg_ctrl #(
  parameter int          N_DIGITS         = 8,
  parameter logic [15:0] DEFAULT_PRESCALE = 16'd12499,
  parameter int          BLINK_LOG2       = 6
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [4:0]          i_wb_adr,
  input  logic [31:0]         i_wb_dat,
  input  logic [3:0]          i_wb_sel,
  input  logic                i_wb_we,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  output logic [31:0]         o_wb_rdt,
  output logic                o_wb_ack,
  output logic [N_DIGITS-1:0] o_an,
  output logic [6:0]          o_seg,
  output logic                o_dp,
  output logic                o_frame
);

  localparam logic [2:0] LAST_IDX = 3'(N_DIGITS - 1);

  // config / bus state
  logic                  ack_q;
  logic [31:0]           rdt_q, rdt_d;
  logic [3:0]            ctrl_q;        // {SYNC, BLINK_EN, DECODE, EN}
  logic [7:0]            bright_q;
  logic [15:0]           prescale_q;
  logic [7:0][7:0]       dig_stg_q;
  logic [7:0][7:0]       dig_act_q;
  logic [7:0]            mask_q;
  logic [15:0]           frame_cnt_q;

  // scan state
  logic [15:0]           slot_q, slot_d;
  logic [2:0]            idx_q, idx_d;
  logic [7:0]            pwm_q, pwm_d;
  logic [BLINK_LOG2-1:0] blink_cnt_q;
  logic                  phase_q;
  logic                  frame_evt;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d, frame_q;

  logic       req, wr, en, lit;
  logic [2:0] wsel;
  logic [7:0] cur;
  logic       unused_adr;

  assign req        = i_wb_cyc & i_wb_stb & ~ack_q;
  assign wr         = req & i_wb_we;
  assign wsel       = i_wb_adr[4:2];
  assign en         = ctrl_q[0];
  assign unused_adr = ^i_wb_adr[1:0];

  always_comb begin
    rdt_d = '0;
    case (wsel)
      3'd0:    rdt_d = {16'h0, bright_q, 4'h0, ctrl_q};
      3'd1:    rdt_d = {16'h0, prescale_q};
      3'd2:    rdt_d = dig_stg_q[3:0];
      3'd3:    rdt_d = dig_stg_q[7:4];
      3'd4:    rdt_d = {24'h0, mask_q};
      3'd5:    rdt_d = {16'h0, frame_cnt_q};
      default: rdt_d = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q      <= 1'b0;
      rdt_q      <= '0;
      ctrl_q     <= '0;
      bright_q   <= '0;
      prescale_q <= DEFAULT_PRESCALE;
      dig_stg_q  <= '0;
      mask_q     <= '0;
    end else begin
      ack_q <= i_wb_cyc & i_wb_stb & ~ack_q;
      if (req && !i_wb_we) rdt_q <= rdt_d;
      if (wr) begin
        case (wsel)
          3'd0: begin
            if (i_wb_sel[0]) ctrl_q   <= i_wb_dat[3:0];
            if (i_wb_sel[1]) bright_q <= i_wb_dat[15:8];
          end
          3'd1: begin
            if (i_wb_sel[0]) prescale_q[7:0]  <= i_wb_dat[7:0];
            if (i_wb_sel[1]) prescale_q[15:8] <= i_wb_dat[15:8];
          end
          3'd2: for (int b = 0; b < 4; b++)
                  if (i_wb_sel[b]) dig_stg_q[b] <= i_wb_dat[8*b +: 8];
          3'd3: for (int b = 0; b < 4; b++)
                  if (i_wb_sel[b]) dig_stg_q[4+b] <= i_wb_dat[8*b +: 8];
          3'd4: if (i_wb_sel[0]) mask_q <= i_wb_dat[7:0];
          default: ;
        endcase
      end
    end
  end

  // >= so a PRESCALE write below the running count wraps on the next cycle
  always_comb begin
    slot_d    = '0;
    idx_d     = '0;
    pwm_d     = '0;
    frame_evt = 1'b0;
    if (en) begin
      pwm_d = pwm_q + 8'd1;
      idx_d = idx_q;
      if (slot_q >= prescale_q) begin
        if (idx_q == LAST_IDX) frame_evt = 1'b1;
        else                   idx_d     = idx_q + 3'd1;
      end else begin
        slot_d = slot_q + 16'd1;
      end
      if (frame_evt) idx_d = '0;
    end
  end

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

  // slot 0 is kept dark so the previous digit's segments never ghost
  always_comb begin
    cur  = dig_act_q[idx_q];
    lit  = en & cur[7] & (slot_q != '0) & (pwm_q <= bright_q) &
           ~(ctrl_q[2] & phase_q & mask_q[idx_q]);
    an_d = '1;
    for (int i = 0; i < N_DIGITS; i++)
      an_d[i] = ~(lit && (idx_q == 3'(i)));
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (en) begin
      seg_d = ctrl_q[1] ? hex7(cur[3:0]) : cur[6:0];
      dp_d  = ctrl_q[1] ? ~cur[4] : 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      slot_q      <= '0;
      idx_q       <= '0;
      pwm_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      frame_cnt_q <= '0;
      dig_act_q   <= '0;
      an_q        <= '1;
      seg_q       <= 7'h7F;
      dp_q        <= 1'b1;
      frame_q     <= 1'b0;
    end else begin
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      pwm_q   <= pwm_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      frame_q <= frame_evt;
      if (!ctrl_q[3] || frame_evt) dig_act_q <= dig_stg_q;
      if (frame_evt) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
        blink_cnt_q <= blink_cnt_q + 1'b1;
        if (&blink_cnt_q) phase_q <= ~phase_q;
      end
    end
  end

  assign o_wb_ack = ack_q;
  assign o_wb_rdt = rdt_q;
  assign o_an     = an_q;
  assign o_seg    = seg_q;
  assign o_dp     = dp_q;
  assign o_frame  = frame_q;

endmodule

// File: tb/tb_swervolf_sevseg_ctrl.sv
// Directed bench for swervolf_sevseg_ctrl: register table plus hand-built
// scan, sync, brightness, blink and reset sequences.
module tb_swervolf_sevseg_ctrl;

  logic        clk = 1'b0, rst = 1'b1;
  logic [4:0]  adr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;
  logic        we = 1'b0, cyc = 1'b0, stb = 1'b0;
  logic [31:0] rdt;
  logic        ack;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp, frame;
  int          tests = 0, errs = 0;

  typedef struct { logic [4:0] adr; logic [3:0] sel; logic [31:0] wdat; logic [31:0] exp; } wr_vec_t;
  typedef struct { logic [4:0] adr; logic [31:0] exp; } rd_vec_t;
  typedef logic [7:0][6:0] seg8_t;

  always #5 clk = ~clk;

  swervolf_sevseg_ctrl #(.N_DIGITS(8), .BLINK_LOG2(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_sel(sel),
    .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_rdt(rdt), .o_wb_ack(ack),
    .o_an(an), .o_seg(seg), .o_dp(dp), .o_frame(frame)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wb_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk); adr = a; wdat = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    chk("wr_ack", {31'b0, ack}, 32'd1);
    @(negedge clk); cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_read(input logic [4:0] a, output logic [31:0] d);
    @(negedge clk); adr = a; sel = 4'hF; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    chk("rd_ack", {31'b0, ack}, 32'd1);
    d = rdt;
    @(negedge clk); cyc = 1'b0; stb = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  // returns on the negedge where o_frame is high
  task automatic wait_frame();
    bit got = 1'b0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (frame) got = 1'b1;
    end
    tests++;
    if (!got) begin errs++; $display("FAIL wait_frame: got timeout expected o_frame"); end
  endtask

  function automatic seg8_t sg(input logic [6:0] d0, d1, d2, d3, d4, d5, d6, d7);
    return {d7, d6, d5, d4, d3, d2, d1, d0};
  endfunction

  // PRESCALE=3 frame: cycle c (1..32) after o_frame shows digit (c-1)/4, slot (c-1)%4.
  // Caller sits on the negedge for cycle c0-1.
  task automatic check_span(input int c0, input int c1, input seg8_t segs,
                            input logic [7:0] ens, input logic [7:0] dps, input string nm);
    logic [7:0] one, an_e;
    int d, s;
    one = 8'h01;
    for (int c = c0; c <= c1; c++) begin
      @(negedge clk);
      d = (c - 1) / 4;
      s = (c - 1) % 4;
      an_e = (ens[d] && s != 0) ? ~(one << d) : 8'hFF;
      chk($sformatf("%s c%0d", nm, c), {15'b0, an, seg, dp, frame},
          {15'b0, an_e, segs[d], dps[d], (c == 32)});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rd_vec_t     rv[6];
    wr_vec_t     wv[12];
    logic [31:0] r, fc1, fc2;
    int          lowc;

    rv[0] = '{5'h00, 32'h0};
    rv[1] = '{5'h04, 32'd12499};
    rv[2] = '{5'h08, 32'h0};
    rv[3] = '{5'h0C, 32'h0};
    rv[4] = '{5'h10, 32'h0};
    rv[5] = '{5'h14, 32'h0};

    wv[0]  = '{5'h00, 4'hF, 32'hFFFF_FF0E, 32'h0000_FF0E};
    wv[1]  = '{5'h04, 4'hF, 32'hABCD_1234, 32'h0000_1234};
    wv[2]  = '{5'h08, 4'hF, 32'h8F81_8880, 32'h8F81_8880};
    wv[3]  = '{5'h0C, 4'hF, 32'h1122_3344, 32'h1122_3344};
    wv[4]  = '{5'h10, 4'hF, 32'hFFFF_FFA5, 32'h0000_00A5};
    wv[5]  = '{5'h18, 4'hF, 32'hFFFF_FFFF, 32'h0};
    wv[6]  = '{5'h14, 4'hF, 32'h0000_FFFF, 32'h0};
    wv[7]  = '{5'h08, 4'h2, 32'h0000_8A00, 32'h8F81_8A80};
    wv[8]  = '{5'h04, 4'h1, 32'h0000_0077, 32'h0000_1277};
    wv[9]  = '{5'h00, 4'h2, 32'h0000_3C00, 32'h0000_3C0E};
    wv[10] = '{5'h0C, 4'h9, 32'hAA00_00BB, 32'hAA22_33BB};
    wv[11] = '{5'h1C, 4'hF, 32'hFFFF_FFFF, 32'h0};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_outputs", {21'b0, an, seg, dp, frame, ack}, {21'b0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
    chk("rst_rdt", rdt, 32'h0);
    for (int i = 0; i < 6; i++) begin
      wb_read(rv[i].adr, r);
      chk($sformatf("rst_reg%0d", i), r, rv[i].exp);
    end
    for (int i = 0; i < 12; i++) begin
      wb_write(wv[i].adr, wv[i].wdat, wv[i].sel);
      wb_read(wv[i].adr, r);
      chk($sformatf("reg_vec%0d", i), r, wv[i].exp);
    end

    // basic decoded scan, then FRAME_CNT increments once per frame
    do_reset();
    wb_write(5'h04, 32'd3, 4'hF);
    wb_write(5'h08, 32'h8F81_8880, 4'hF);
    wb_write(5'h00, 32'h0000_FF03, 4'hF);
    wait_frame();
    check_span(1, 32, sg(7'h40, 7'h00, 7'h79, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40),
               8'h0F, 8'hFF, "scan");
    wb_read(5'h14, fc1);
    wait_frame();
    wb_read(5'h14, fc2);
    chk("frame_cnt_inc", fc2, fc1 + 32'd1);

    // byte-lane write touches only digit 1
    wb_write(5'h08, 32'h0000_8A00, 4'h2);
    wb_read(5'h08, r);
    chk("byte_wr_reg", r, 32'h8F81_8A80);
    wait_frame();
    check_span(1, 32, sg(7'h40, 7'h08, 7'h79, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40),
               8'h0F, 8'hFF, "byte_wr");

    // SYNC=1: mid-frame write held until the frame boundary
    wb_write(5'h00, 32'h0000_FF0B, 4'hF);
    wait_frame();
    wb_write(5'h08, 32'h8584_8382, 4'hF);
    check_span(3, 32, sg(7'h40, 7'h08, 7'h79, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40),
               8'h0F, 8'hFF, "sync_old");
    check_span(1, 32, sg(7'h24, 7'h30, 7'h19, 7'h12, 7'h40, 7'h40, 7'h40, 7'h40),
               8'h0F, 8'hFF, "sync_new");

    // SYNC=0: new value visible two cycles after the write commits; dp on digit 3
    wb_write(5'h00, 32'h0000_FF03, 4'hF);
    wait_frame();
    wb_write(5'h08, 32'h9687_8889, 4'hF);
    @(negedge clk);
    check_span(4, 32, sg(7'h10, 7'h00, 7'h78, 7'h02, 7'h40, 7'h40, 7'h40, 7'h40),
               8'h0F, 8'hF7, "nosync");

    // raw segment mode, dp stays off even with bit 4 set
    wb_write(5'h00, 32'h0000_FF01, 4'hF);
    wb_write(5'h08, 32'h0000_00BA, 4'hF);
    wait_frame();
    check_span(1, 32, sg(7'h3A, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00),
               8'h01, 8'hFF, "raw");

    // EN=0 forces reset-valued outputs
    wb_write(5'h00, 32'h0, 4'hF);
    @(negedge clk);
    lowc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (an != 8'hFF || seg != 7'h7F || dp != 1'b1 || frame != 1'b0) lowc++;
    end
    chk("en_off_idle", lowc, 0);

    // brightness: slot and pwm counters both start at 0, so they stay aligned
    wb_write(5'h04, 32'd255, 4'hF);
    wb_write(5'h08, 32'h8080_8080, 4'hF);
    wb_write(5'h00, 32'h0000_3F03, 4'hF);
    lowc = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      if (an != 8'hFF) lowc++;
    end
    chk("pwm_3f", lowc, 4 * 63);
    wb_write(5'h00, 32'h0000_FF00, 4'h2);
    lowc = 0;
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      if (an != 8'hFF) lowc++;
    end
    chk("pwm_ff", lowc, 4 * 255);

    // blink with BLINK_LOG2=1: frames 0,1 lit, 2,3 dark, 4 lit
    do_reset();
    wb_write(5'h04, 32'd3, 4'hF);
    wb_write(5'h08, 32'h8F81_8880, 4'hF);
    wb_write(5'h10, 32'h1, 4'hF);
    wb_write(5'h00, 32'h0000_FF07, 4'hF);
    wait_frame();
    for (int f = 1; f <= 4; f++)
      check_span(1, 32, sg(7'h40, 7'h00, 7'h79, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40),
                 (f == 2 || f == 3) ? 8'h0E : 8'h0F, 8'hFF, $sformatf("blink_f%0d", f));
    wb_read(5'h14, r);
    chk("frame_cnt_abs", r, 32'd5);

    // reset mid-frame
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_out", {21'b0, an, seg, dp, frame, ack}, {21'b0, 8'hFF, 7'h7F, 1'b1, 1'b0, 1'b0});
    chk("rst_mid_rdt", rdt, 32'h0);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wb_read(rv[i].adr, r);
      chk($sformatf("rst_mid_reg%0d", i), r, rv[i].exp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
